// File: rtl/semaphore_pkg.sv
// Shared types and width helpers for the semaphore / delay-timer client side.
package semaphore_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } arb_state_t;

    // Width of a client index; never narrower than one bit.
    function automatic int unsigned client_idx_width(input int unsigned num_clients);
        return (num_clients > 1) ? $clog2(num_clients) : 1;
    endfunction

    // Width of a watchdog able to hold the value TIMEOUT itself.
    function automatic int unsigned watchdog_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter
    import semaphore_pkg::*;
#(
    parameter  int unsigned NUM_CLIENTS = 4,
    localparam int unsigned IW          = client_idx_width(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [IW-1:0]          ptr,
    output logic                   valid,
    output logic [IW-1:0]          winner,
    output logic [NUM_CLIENTS-1:0] onehot
);

    logic [IW-1:0] cand;

    // ptr < NUM_CLIENTS, so a single conditional subtract implements the wrap.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            cand = ((32'(ptr) + i) >= NUM_CLIENTS) ? IW'(32'(ptr) + i - NUM_CLIENTS)
                                                   : IW'(32'(ptr) + i);
            if (!valid && req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
        onehot = valid ? (NUM_CLIENTS'(1) << winner) : '0;
    end

endmodule

// File: rtl/timer_client_arbiter.sv
// Round-robin owner of the shared delay counter: start pulse, done wait, ack or watchdog abort.
module timer_client_arbiter
    import semaphore_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_CLIENTS-1:0] req,
    output logic [NUM_CLIENTS-1:0] grant,
    output logic [NUM_CLIENTS-1:0] ack,
    output logic                   tmr_start,
    input  logic                   tmr_done,
    output logic                   busy,
    output logic                   timeout_err,
    input  logic                   err_clear
);

    localparam int unsigned IW = client_idx_width(NUM_CLIENTS);
    localparam int unsigned WW = watchdog_width(TIMEOUT);

    arb_state_t             state_q, state_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [WW-1:0]          wd_q, wd_d;
    logic [NUM_CLIENTS-1:0] grant_q, grant_d;
    logic [NUM_CLIENTS-1:0] ack_q, ack_d;
    logic                   start_q, start_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;

    logic                   arb_valid;
    logic [IW-1:0]          arb_winner;
    logic [NUM_CLIENTS-1:0] arb_onehot;

    rr_arbiter #(.NUM_CLIENTS(NUM_CLIENTS)) u_rr (
        .req    (req),
        .ptr    (ptr_q),
        .valid  (arb_valid),
        .winner (arb_winner),
        .onehot (arb_onehot)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            wd_q    <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    // Next state and next registered outputs; a timeout set overrides err_clear.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        grant_d = grant_q;
        ack_d   = '0;
        start_d = 1'b0;
        err_d   = err_q & ~err_clear;

        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_d = arb_onehot;
                    ptr_d   = (32'(arb_winner) == NUM_CLIENTS - 1) ? '0 : arb_winner + IW'(1);
                    start_d = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (tmr_done) begin
                    ack_d   = grant_q;
                    state_d = RELEASE;
                end else if (wd_q == WW'(TIMEOUT)) begin
                    grant_d = '0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            RELEASE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign grant       = grant_q;
    assign ack         = ack_q;
    assign tmr_start   = start_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_timer_client_arbiter.sv
// Directed bench for timer_client_arbiter paired with a 2-bit delay counter model.
module tb_timer_client_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] ack;
    logic       tmr_start;
    logic       tmr_done;
    logic       busy;
    logic       timeout_err;
    logic       err_clear;

    // Counter model controls: cnt_en gates its done, force_done injects one.
    logic       cnt_en;
    logic       force_done;
    logic       running = 1'b0;
    logic [1:0] cnt = 2'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    timer_client_arbiter #(.NUM_CLIENTS(4), .TIMEOUT(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .grant       (grant),
        .ack         (ack),
        .tmr_start   (tmr_start),
        .tmr_done    (tmr_done),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clear   (err_clear)
    );

    // 2-bit counter: start sampled at an edge, done high in the 4th following cycle.
    always @(posedge clk) begin
        if (tmr_start) begin
            running <= 1'b1;
            cnt     <= 2'd0;
        end else if (running) begin
            if (cnt == 2'd3) running <= 1'b0;
            else             cnt     <= cnt + 2'd1;
        end
    end

    assign tmr_done = (cnt_en && running && (cnt == 2'd3)) || force_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        req        = 4'b0000;
        err_clear  = 1'b0;
        force_done = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [3:0] ack;
        logic       start;
        logic       busy;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [3:0] exp_g;
        logic       ack_seen;

        cnt_en = 1'b1;
        do_reset();
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_ack", 32'(ack), 32'h0);
        check("reset_start", 32'(tmr_start), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_err", 32'(timeout_err), 32'h0);

        // Single request: entry k drives req in cycle k, expects outputs of cycle k+1.
        vecs[0] = '{4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b1};
        vecs[1] = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b1};
        vecs[2] = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b1};
        vecs[3] = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b1};
        vecs[4] = '{4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b1};
        vecs[5] = '{4'b0100, 4'b0100, 4'b0100, 1'b0, 1'b1};
        vecs[6] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        vecs[7] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        for (int k = 0; k < 8; k++) begin
            req = vecs[k].req;
            tick();
            check($sformatf("single_grant_c%0d", k + 1), 32'(grant), 32'(vecs[k].grant));
            check($sformatf("single_ack_c%0d", k + 1), 32'(ack), 32'(vecs[k].ack));
            check($sformatf("single_start_c%0d", k + 1), 32'(tmr_start), 32'(vecs[k].start));
            check($sformatf("single_busy_c%0d", k + 1), 32'(busy), 32'(vecs[k].busy));
        end

        // Round-robin with all requests held: one run every 7 cycles.
        do_reset();
        req = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            exp_g = 4'b0001 << (r % 4);
            tick();
            check($sformatf("rr_grant_run%0d", r), 32'(grant), 32'(exp_g));
            check($sformatf("rr_start_run%0d", r), 32'(tmr_start), 32'h1);
            repeat (5) tick();
            check($sformatf("rr_ack_run%0d", r), 32'(ack), 32'(exp_g));
            tick();
            check($sformatf("rr_gap_run%0d", r), 32'(grant), 32'h0);
        end
        req = 4'b0000;
        repeat (8) tick();

        // Watchdog abort with a silent counter, then err_clear.
        cnt_en = 1'b0;
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        check("to_grant_c1", 32'(grant), 32'h1);
        ack_seen = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            tick();
            if (ack !== 4'b0000) ack_seen = 1'b1;
        end
        check("to_grant_c10", 32'(grant), 32'h1);
        check("to_err_c10", 32'(timeout_err), 32'h0);
        tick();
        check("to_grant_c11", 32'(grant), 32'h0);
        check("to_err_c11", 32'(timeout_err), 32'h1);
        check("to_busy_c11", 32'(busy), 32'h0);
        check("to_ack_c11", 32'(ack), 32'h0);
        check("to_no_ack", 32'(ack_seen), 32'h0);
        repeat (3) tick();
        check("to_err_sticky", 32'(timeout_err), 32'h1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("to_err_cleared", 32'(timeout_err), 32'h0);

        // Done arriving on the same cycle the watchdog reaches TIMEOUT.
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        repeat (9) tick();
        check("col_grant_c10", 32'(grant), 32'h1);
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        check("col_ack_c11", 32'(ack), 32'h1);
        check("col_err_c11", 32'(timeout_err), 32'h0);
        tick();
        check("col_grant_c12", 32'(grant), 32'h0);
        check("col_err_c12", 32'(timeout_err), 32'h0);
        check("col_busy_c12", 32'(busy), 32'h0);
        cnt_en = 1'b1;
        repeat (4) tick();

        // Asynchronous reset in WAIT; the counter keeps running and its done is stale.
        do_reset();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        tick();
        check("mid_busy_before", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #1;
        check("mid_grant", 32'(grant), 32'h0);
        check("mid_busy", 32'(busy), 32'h0);
        check("mid_start", 32'(tmr_start), 32'h0);
        check("mid_err", 32'(timeout_err), 32'h0);
        tick();
        reset_n = 1'b1;
        ack_seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (ack !== 4'b0000 || busy !== 1'b0 || grant !== 4'b0000) ack_seen = 1'b1;
        end
        check("mid_stale_done_ignored", 32'(ack_seen), 32'h0);

        // Request withdrawn after one cycle still completes with an ack.
        do_reset();
        req = 4'b0001;
        tick();
        req = 4'b0000;
        check("wd_grant_c1", 32'(grant), 32'h1);
        repeat (5) tick();
        check("wd_ack_c6", 32'(ack), 32'h1);
        tick();
        check("wd_grant_c7", 32'(grant), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
